// File: rtl/oc_bus_pullup_model_pkg.sv
// Shared types and helpers for the open-collector bus termination model.
//   line_state_t : per-line resolved state (HIGH, LOW, RISE)
//   clog2_sat    : ceiling log2 that never returns less than 1
//   LOW_CNT_W    : width of the saturating per-line low-time counter
package cadr_term_pkg;

  typedef enum logic [1:0] {
    LS_HIGH,
    LS_LOW,
    LS_RISE
  } line_state_t;

  localparam int unsigned LOW_CNT_W = 16;

  // Ceiling log2 with a floor of 1, so that a counter sized by it always
  // has at least one bit.
  function automatic int unsigned clog2_sat(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << w) < value) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/oc_bus_pullup_model_if.sv
// Bus-side signal bundle of the pull-up model.
//   pd_n      : NDRV*WIDTH pull-down requests, 0 = pull low, bit d*WIDTH+i -> line i
//   stuck_clr : clear all stuck flags and low-time counters
//   bus_out   : resolved line levels
//   rising    : line released, rise time in progress
//   stuck     : sticky long-low flag per line
// master = driver/bench side, slave = the bus model.
interface oc_bus_pullup_model_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDRV  = 2
);
  logic [NDRV*WIDTH-1:0] pd_n;
  logic                  stuck_clr;
  logic [WIDTH-1:0]      bus_out;
  logic [WIDTH-1:0]      rising;
  logic [WIDTH-1:0]      stuck;

  modport master (
    output pd_n, stuck_clr,
    input  bus_out, rising, stuck
  );

  modport slave (
    input  pd_n, stuck_clr,
    output bus_out, rising, stuck
  );
endinterface

// File: rtl/oc_bus_pullup_model_line.sv
// One terminated open-collector line: HIGH/LOW/RISE state machine with an
// RC rise-time counter, plus a saturating low-time counter and sticky flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   pull         : 1 = at least one driver pulls this line low
//   stuck_clr    : zero the stuck flag and low-time counter
//   level        : registered line level (state == HIGH)
//   rising       : registered rise-in-progress (state == RISE)
//   stuck        : set when the line has been low STUCK_CYCLES edges
module oc_line_pullup
  import cadr_term_pkg::*;
#(
  parameter int unsigned RISE_CYCLES  = 2,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pull,
  input  logic stuck_clr,
  output logic level,
  output logic rising,
  output logic stuck
);

  localparam int unsigned RW = clog2_sat(RISE_CYCLES + 1);
  localparam logic [RW-1:0] RISE_LOAD = RW'(RISE_CYCLES - 1);
  localparam logic [LOW_CNT_W-1:0] STUCK_LIM = LOW_CNT_W'(STUCK_CYCLES);

  line_state_t state, state_next;
  logic [RW-1:0] rise_cnt, rise_cnt_next;
  logic [LOW_CNT_W-1:0] low_cnt, low_cnt_next, low_inc;
  logic stuck_q, stuck_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LS_HIGH;
      rise_cnt <= '0;
      low_cnt  <= '0;
      stuck_q  <= 1'b0;
    end else begin
      state    <= state_next;
      rise_cnt <= rise_cnt_next;
      low_cnt  <= low_cnt_next;
      stuck_q  <= stuck_next;
    end
  end

  always_comb begin
    state_next    = state;
    rise_cnt_next = rise_cnt;
    unique case (state)
      LS_HIGH: begin
        if (pull) state_next = LS_LOW;
      end
      LS_LOW: begin
        if (!pull) begin
          state_next    = LS_RISE;
          rise_cnt_next = RISE_LOAD;
        end
      end
      LS_RISE: begin
        // A re-pull aborts the rise so the line never pulses high.
        if (pull) begin
          state_next    = LS_LOW;
          rise_cnt_next = '0;
        end else if (rise_cnt == '0) begin
          state_next = LS_HIGH;
        end else begin
          rise_cnt_next = rise_cnt - 1'b1;
        end
      end
      default: state_next = LS_HIGH;
    endcase
  end

  always_comb begin
    low_inc      = (low_cnt == '1) ? low_cnt : low_cnt + 1'b1;
    low_cnt_next = low_cnt;
    stuck_next   = stuck_q;
    // Clear takes priority over a set landing on the same edge.
    if (stuck_clr) begin
      low_cnt_next = '0;
      stuck_next   = 1'b0;
    end else if (pull) begin
      low_cnt_next = low_inc;
      if (low_inc >= STUCK_LIM) stuck_next = 1'b1;
    end else begin
      low_cnt_next = '0;
    end
  end

  assign level  = (state == LS_HIGH);
  assign rising = (state == LS_RISE);
  assign stuck  = stuck_q;

endmodule

// File: rtl/oc_bus_pullup_model.sv
// Resistor-pack terminated open-collector bus: WIDTH lines, each the
// wired-AND of NDRV active-low pull-down drivers, with modelled rise time
// and stuck-low detection. All outputs come straight from registers.
//   clk     : bus model clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport (pd_n, stuck_clr in; bus_out, rising, stuck out);
//             the connected interface must use the same WIDTH and NDRV.
module oc_bus_pullup_model
  import cadr_term_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NDRV         = 2,
  parameter int unsigned RISE_CYCLES  = 2,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  oc_bus_pullup_model_if.slave bus
);

  logic [WIDTH-1:0] pull;
  logic [WIDTH-1:0] level_v;
  logic [WIDTH-1:0] rising_v;
  logic [WIDTH-1:0] stuck_v;

  // A line is pulled when any driver on it requests low.
  always_comb begin
    pull = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned d = 0; d < NDRV; d++) begin
        if (!bus.pd_n[d*WIDTH + i]) pull[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_line
    oc_line_pullup #(
      .RISE_CYCLES (RISE_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_line (
      .clk      (clk),
      .reset_n  (reset_n),
      .pull     (pull[g]),
      .stuck_clr(bus.stuck_clr),
      .level    (level_v[g]),
      .rising   (rising_v[g]),
      .stuck    (stuck_v[g])
    );
  end

  assign bus.bus_out = level_v;
  assign bus.rising  = rising_v;
  assign bus.stuck   = stuck_v;

endmodule
